// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it into the register file,
// and serves two combinational read ports with same-cycle write-through bypass.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [DATA_W-1:0] ReadData_i,
  input  logic [DATA_W-1:0] ALUdata_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [ADDR_W-1:0] RS1addr_i,
  input  logic [ADDR_W-1:0] RS2addr_i,
  output logic [DATA_W-1:0] RS1data_o,
  output logic [DATA_W-1:0] RS2data_o,
  output logic [DATA_W-1:0] WBdata_o,
  output logic              WBvalid_o,
  output logic [CNT_W-1:0]  RetireCnt_o
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [DATA_W-1:0] wb_data;
  logic              wb_valid;

  always_comb begin
    wb_data  = MemtoReg_i ? ReadData_i : ALUdata_i;
    wb_valid = RegWrite_i & (RDaddr_i != '0) & ~rst_i;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wb_valid) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      if (wb_valid) regs_q[RDaddr_i] <= wb_data;
      cnt_q <= cnt_d;
    end
  end

  // Bypass is gated by wb_valid, so it is also disabled during reset.
  always_comb begin
    RS1data_o = '0;
    if (!rst_i && RS1addr_i != '0) begin
      if (wb_valid && RDaddr_i == RS1addr_i) RS1data_o = wb_data;
      else                                   RS1data_o = regs_q[RS1addr_i];
    end
  end

  always_comb begin
    RS2data_o = '0;
    if (!rst_i && RS2addr_i != '0) begin
      if (wb_valid && RDaddr_i == RS2addr_i) RS2data_o = wb_data;
      else                                   RS2data_o = regs_q[RS2addr_i];
    end
  end

  assign WBdata_o    = wb_data;
  assign WBvalid_o   = wb_valid;
  assign RetireCnt_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!$isunknown(RegWrite_i))
      else $error("RegWrite_i is X outside reset");
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: array-based reference model checked every cycle, plus
// directed scenarios with literal expectations. A second instance uses a 4-bit counter.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite, MemtoReg;
  logic [31:0] ReadData, ALUdata;
  logic [4:0]  RDaddr, RS1addr, RS2addr;
  logic [31:0] RS1data, RS2data, WBdata;
  logic        WBvalid;
  logic [31:0] RetireCnt;
  logic [31:0] RS1data_b, RS2data_b, WBdata_b;
  logic        WBvalid_b;
  logic [3:0]  RetireCnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk_i(clk), .rst_i(rst), .RegWrite_i(RegWrite), .MemtoReg_i(MemtoReg),
    .ReadData_i(ReadData), .ALUdata_i(ALUdata), .RDaddr_i(RDaddr),
    .RS1addr_i(RS1addr), .RS2addr_i(RS2addr), .RS1data_o(RS1data),
    .RS2data_o(RS2data), .WBdata_o(WBdata), .WBvalid_o(WBvalid),
    .RetireCnt_o(RetireCnt)
  );

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .RegWrite_i(RegWrite), .MemtoReg_i(MemtoReg),
    .ReadData_i(ReadData), .ALUdata_i(ALUdata), .RDaddr_i(RDaddr),
    .RS1addr_i(RS1addr), .RS2addr_i(RS2addr), .RS1data_o(RS1data_b),
    .RS2data_o(RS2data_b), .WBdata_o(WBdata_b), .WBvalid_o(WBvalid_b),
    .RetireCnt_o(RetireCnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state plus an unbounded retire count.
  logic [31:0] mregs [32];
  int unsigned mcnt;

  function automatic logic [31:0] m_wb();
    return MemtoReg ? ReadData : ALUdata;
  endfunction

  function automatic logic m_valid();
    return !rst && RegWrite && RDaddr != 5'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'd0;
    if (m_valid() && a == RDaddr) return m_wb();
    return mregs[a];
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mcnt = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      mcnt = 0;
    end else if (m_valid()) begin
      mregs[RDaddr] = m_wb();
      mcnt++;
    end
  end

  bit model_on = 1'b0;
  always @(negedge clk) begin
    if (model_on) begin
      chk("m_rs1",   RS1data,   m_read(RS1addr));
      chk("m_rs2",   RS2data,   m_read(RS2addr));
      chk("m_wbd",   WBdata,    m_wb());
      chk("m_wbv",   {31'd0, WBvalid}, {31'd0, m_valid()});
      chk("m_cnt",   RetireCnt, mcnt);
      chk("m4_rs1",  RS1data_b, m_read(RS1addr));
      chk("m4_rs2",  RS2data_b, m_read(RS2addr));
      chk("m4_cnt",  {28'd0, RetireCnt_b}, mcnt % 16);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic m, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [4:0] d,
                       input logic [4:0] a1, input logic [4:0] a2);
    RegWrite = w; MemtoReg = m; ReadData = rd; ALUdata = alu;
    RDaddr = d; RS1addr = a1; RS2addr = a2;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    step(); step();
    model_on = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd7);
    #1;
    chk("rst_rs1", RS1data, 32'd0);
    chk("rst_wbv", {31'd0, WBvalid}, 32'd0);
    rst = 1'b0;

    // 1: reset clears a written register
    drive(1'b1, 1'b0, 32'd0, 32'h1234, 5'd5, 5'd5, 5'd0);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd0);
    #1 chk("r5_written", RS1data, 32'h1234);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("r5_after_rst", RS1data, 32'd0);
    chk("cnt_after_rst", RetireCnt, 32'd0);

    // 2: ALU writeback
    drive(1'b1, 1'b0, 32'h0BAD_0BAD, 32'hDEADBEEF, 5'd7, 5'd0, 5'd0);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd7, 5'd0);
    #1;
    chk("alu_r7", RS1data, 32'hDEADBEEF);
    chk("alu_cnt", RetireCnt, 32'd1);

    // 3: load writeback with bypass, old value 0x11 must not appear
    drive(1'b1, 1'b0, 32'd0, 32'h11, 5'd3, 5'd0, 5'd0);
    step();
    drive(1'b1, 1'b1, 32'h0000_00FF, 32'h7777_7777, 5'd3, 5'd3, 5'd3);
    #1;
    chk("byp_rs1", RS1data, 32'hFF);
    chk("byp_rs2", RS2data, 32'hFF);
    chk("byp_wbd", WBdata, 32'hFF);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd7);
    #1;
    chk("ld_r3", RS1data, 32'hFF);
    chk("ld_r7", RS2data, 32'hDEADBEEF);
    chk("ld_cnt", RetireCnt, 32'd3);

    // 4: x0 guard
    drive(1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    #1;
    chk("x0_wbv", {31'd0, WBvalid}, 32'd0);
    chk("x0_rs1", RS1data, 32'd0);
    chk("x0_wbd", WBdata, 32'hFFFF_FFFF);
    step();
    #1 chk("x0_cnt", RetireCnt, 32'd3);

    // 5: reset beats a same-edge write
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'd0, 32'h55, 5'd9, 5'd9, 5'd0);
    #1;
    chk("rw_wbv", {31'd0, WBvalid}, 32'd0);
    chk("rw_rs1", RS1data, 32'd0);
    chk("rw_wbd", WBdata, 32'h55);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd9, 5'd7);
    #1;
    chk("rw_r9", RS1data, 32'd0);
    chk("rw_r7", RS2data, 32'd0);
    chk("rw_cnt", RetireCnt, 32'd0);

    // 6: 17 commits to r1
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, i[0], 32'h100 + i, 32'h200 + i, 5'd1, 5'd1, 5'd2);
      step();
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd1, 5'd1);
    #1;
    chk("wrap_cnt4", {28'd0, RetireCnt_b}, 32'd1);
    chk("wrap_cnt32", RetireCnt, 32'd17);
    chk("wrap_r1", RS1data, 32'h111);
    chk("wrap_r1_b", RS2data_b, 32'h111);

    // mixed traffic: bubbles, distinct registers, cross-port bypass
    drive(1'b1, 1'b0, 32'd0, 32'hA5A5_0001, 5'd31, 5'd31, 5'd1);  step();
    drive(1'b0, 1'b0, 32'd0, 32'hFFFF_0000, 5'd31, 5'd31, 5'd30); step();
    drive(1'b1, 1'b1, 32'hC0DE_0002, 32'd0, 5'd30, 5'd31, 5'd30); step();
    drive(1'b1, 1'b0, 32'd0, 32'h0000_0003, 5'd16, 5'd16, 5'd15); step();
    drive(1'b1, 1'b0, 32'd0, 32'h0000_0004, 5'd15, 5'd16, 5'd15); step();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd30, 5'd15);
    #1;
    chk("mix_r30", RS1data, 32'hC0DE_0002);
    chk("mix_r15", RS2data, 32'h4);
    step();

    model_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
